// File: rtl/nibble_serial_addsub_seq_pkg.sv
// Shared definitions for the nibble-serial add/sub sequencer and its adder link.
// Optional signed overflow is enabled with the ADDSUB_OVERFLOW_EN macro.
package addsub_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Two's-complement overflow: like-signed operands producing an opposite-signed sum.
  function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/nibble_serial_addsub_seq_if.sv
// Request, nibble-datapath and result bus of the nibble-serial add/sub sequencer.
// master = environment/adder side, slave = sequencer side.
interface nibble_serial_addsub_seq_if
  import addsub_pkg::*;
#(
  parameter int NIBBLES = 4
);
  localparam int W = NIBBLE_W * NIBBLES;

  logic                in_valid;
  logic                in_ready;
  logic [W-1:0]        op_a;
  logic [W-1:0]        op_b;
  logic                op_sub;
  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic                nib_cin;
  logic                nib_s;
  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;
  logic                out_valid;
  logic                out_ready;
  logic [W-1:0]        result;
  logic                carry;
  logic                ovf;

  modport master (
    output in_valid, op_a, op_b, op_sub, nib_sum, nib_cout, out_ready,
    input  in_ready, nib_a, nib_b, nib_cin, nib_s, out_valid, result, carry, ovf
  );

  modport slave (
    input  in_valid, op_a, op_b, op_sub, nib_sum, nib_cout, out_ready,
    output in_ready, nib_a, nib_b, nib_cin, nib_s, out_valid, result, carry, ovf
  );

endinterface

// File: rtl/nibble_serial_addsub_seq.sv
// Feeds a 4-bit adder one nibble per cycle (LSB first, carry chained) and assembles the result.
// Signed overflow output is live only when ADDSUB_OVERFLOW_EN is defined, otherwise tied to 0.
module nibble_serial_addsub_seq
  import addsub_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input logic clk,
  input logic rst_n,
  nibble_serial_addsub_seq_if.slave bus
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e           state, state_nx;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     a_reg, b_reg, result_reg;
  logic             carry_reg;
  logic             accept;

  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.nib_a     = '0;
    bus.nib_b     = '0;
    bus.nib_cin   = 1'b0;
    bus.nib_s     = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = rst_n;
        if (bus.in_valid && rst_n) state_nx = RUN;
      end
      RUN: begin
        bus.nib_a   = a_reg[idx*NIBBLE_W +: NIBBLE_W];
        bus.nib_b   = b_reg[idx*NIBBLE_W +: NIBBLE_W];
        bus.nib_cin = carry_reg;
        if (idx == LAST_IDX) state_nx = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Operands are only sampled on acceptance; subtract is A + ~B + 1 through add mode.
  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      a_reg <= bus.op_a;
      b_reg <= (bus.op_sub == OP_SUB) ? ~bus.op_b : bus.op_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx        <= '0;
      result_reg <= '0;
      carry_reg  <= 1'b0;
    end else if (state == IDLE && accept) begin
      idx       <= '0;
      carry_reg <= bus.op_sub;
    end else if (state == RUN) begin
      result_reg[idx*NIBBLE_W +: NIBBLE_W] <= bus.nib_sum;
      carry_reg                            <= bus.nib_cout;
      idx                                  <= idx + 1'b1;
    end
  end

  assign bus.result = result_reg;
  assign bus.carry  = carry_reg;

`ifdef ADDSUB_OVERFLOW_EN
  logic ovf_reg;

  // Captured on the final nibble, when the result MSB is on nib_sum.
  always_ff @(posedge clk) begin
    if (!rst_n)
      ovf_reg <= 1'b0;
    else if (state == RUN && idx == LAST_IDX)
      ovf_reg <= ovf_calc(a_reg[W-1], b_reg[W-1], bus.nib_sum[NIBBLE_W-1]);
  end

  assign bus.ovf = ovf_reg;
`else
  assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_addsub_seq.sv
// Directed self-checking bench for nibble_serial_addsub_seq with a behavioural 4-bit adder/subtractor.
// Expected overflow follows the ADDSUB_OVERFLOW_EN macro.
module tb_nibble_serial_addsub_seq;
  import addsub_pkg::*;

`ifdef ADDSUB_OVERFLOW_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [3:0] cin_seen;
  logic       s_seen;
  logic [3:0] nb_first;
  int         lat;

  nibble_serial_addsub_seq_if #(.NIBBLES(4)) bus ();

  nibble_serial_addsub_seq #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // adder_subtractor_4bit: s=0 adds with cin, s=1 subtracts with forced cin
  always_comb begin
    if (bus.nib_s) {bus.nib_cout, bus.nib_sum} = {1'b0, bus.nib_a} + {1'b0, ~bus.nib_b} + 5'd1;
    else           {bus.nib_cout, bus.nib_sum} = {1'b0, bus.nib_a} + {1'b0, bus.nib_b} + {4'd0, bus.nib_cin};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the first RUN cycle.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic sub);
    bus.in_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.op_sub   = sub;
    check("acc_rdy", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.op_a     = ~a;
    bus.op_b     = ~b;
    bus.op_sub   = ~sub;
  endtask

  // lat counts cycles from the accept cycle (0) to the first out_valid cycle.
  task automatic wait_done();
    lat      = 1;
    cin_seen = '0;
    s_seen   = 1'b0;
    nb_first = '0;
    while (!bus.out_valid && lat < 20) begin
      if (lat <= 4) cin_seen[lat-1] = bus.nib_cin;
      if (lat == 1) nb_first = bus.nib_b;
      s_seen = s_seen | bus.nib_s;
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) check("timeout", 32'd0, 32'd1);
  endtask

  task automatic finish_op();
    bus.out_ready = 1'b1;
    check("done_rdy", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("post_vld", {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.op_sub    = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_vld",    {31'd0, bus.out_valid}, 32'd0);
    check("rst_res",    {16'd0, bus.result},    32'd0);
    check("rst_carry",  {31'd0, bus.carry},     32'd0);
    check("rst_ovf",    {31'd0, bus.ovf},       32'd0);
    check("rst_rdy",    {31'd0, bus.in_ready},  32'd0);
    check("rst_nib",    {22'd0, bus.nib_a, bus.nib_b, bus.nib_cin, bus.nib_s}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_rdy",    {31'd0, bus.in_ready},  32'd1);

    // 0x1234 + 0x0FCD
    start_op(16'h1234, 16'h0FCD, OP_ADD);
    wait_done();
    check("add_lat",    lat,                    32'd5);
    check("add_res",    {16'd0, bus.result},    32'h2201);
    check("add_carry",  {31'd0, bus.carry},     32'd0);
    check("add_ovf",    {31'd0, bus.ovf},       32'd0);
    finish_op();

    // 0x0005 - 0x0007
    start_op(16'h0005, 16'h0007, OP_SUB);
    wait_done();
    check("sub_res",    {16'd0, bus.result},    32'hFFFE);
    check("sub_carry",  {31'd0, bus.carry},     32'd0);
    check("sub_ovf",    {31'd0, bus.ovf},       32'd0);
    check("sub_cin0",   {31'd0, cin_seen[0]},   32'd1);
    check("sub_nibs",   {31'd0, s_seen},        32'd0);
    check("sub_nb0",    {28'd0, nb_first},      32'h8);
    finish_op();

    // 0x7FFF + 0x0001
    start_op(16'h7FFF, 16'h0001, OP_ADD);
    wait_done();
    check("pos_res",    {16'd0, bus.result},    32'h8000);
    check("pos_carry",  {31'd0, bus.carry},     32'd0);
    check("pos_ovf",    {31'd0, bus.ovf},       {31'd0, OVF_EN});
    finish_op();

    // 0x8000 - 0x0001
    start_op(16'h8000, 16'h0001, OP_SUB);
    wait_done();
    check("neg_res",    {16'd0, bus.result},    32'h7FFF);
    check("neg_carry",  {31'd0, bus.carry},     32'd1);
    check("neg_ovf",    {31'd0, bus.ovf},       {31'd0, OVF_EN});
    finish_op();

    // 0xFFFF + 0x0001: carry ripples through every nibble
    start_op(16'hFFFF, 16'h0001, OP_ADD);
    wait_done();
    check("wrap_res",   {16'd0, bus.result},    32'h0000);
    check("wrap_carry", {31'd0, bus.carry},     32'd1);
    check("wrap_cin",   {28'd0, cin_seen},      32'hE);
    finish_op();

    // Back-pressure in DONE with a pending request
    start_op(16'h1111, 16'h2222, OP_ADD);
    wait_done();
    bus.in_valid = 1'b1;
    bus.op_a     = 16'h0001;
    bus.op_b     = 16'h0001;
    bus.op_sub   = OP_ADD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_res", {16'd0, bus.result},   32'h3333);
      check("hold_vld", {31'd0, bus.out_valid}, 32'd1);
      check("hold_rdy", {31'd0, bus.in_ready},  32'd0);
    end
    finish_op();
    check("hs_rdy",     {31'd0, bus.in_ready},  32'd1);
    start_op(16'h0001, 16'h0001, OP_ADD);
    wait_done();
    check("next_lat",   lat,                    32'd5);
    check("next_res",   {16'd0, bus.result},    32'h0002);
    finish_op();

    // Reset after two RUN cycles discards the operation
    start_op(16'h1234, 16'h1111, OP_ADD);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_vld",    {31'd0, bus.out_valid}, 32'd0);
    check("mid_res",    {16'd0, bus.result},    32'd0);
    check("mid_nib",    {22'd0, bus.nib_a, bus.nib_b, bus.nib_cin, bus.nib_s}, 32'd0);
    check("mid_rdy",    {31'd0, bus.in_ready},  32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rel",    {31'd0, bus.in_ready},  32'd1);
    start_op(16'h0001, 16'h0002, OP_ADD);
    wait_done();
    check("fresh_res",  {16'd0, bus.result},   32'h0003);
    check("fresh_carry",{31'd0, bus.carry},     32'd0);
    finish_op();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
